regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (RegWrite / Write_Reg_Num / reg_write_data) between two writers:
- Requester A: the pipeline writeback stage.
- Requester B: the multi-cycle unit (mult/div, late load).

A has fixed priority. A starvation counter guarantees B a slot. The grant is registered one cycle before the register-file write. Writes to $0 are accepted and discarded.

Parameters:
MAX_WAIT, 4, consecutive cycles B may be refused while valid before it is force-granted (legal range 1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
a_valid  input  1  writeback stage has a result
a_ready  output  1  A transfer accepted this cycle
a_reg  input  5  A destination register
a_data  input  32  A write data
b_valid  input  1  multi-cycle unit has a result
b_ready  output  1  B transfer accepted this cycle
b_reg  input  5  B destination register
b_data  input  32  B write data
RegWrite  output  1  register-file write enable (registered)
Write_Reg_Num  output  5  register-file write address (registered)
reg_write_data  output  32  register-file write data (registered)
b_starved  output  1  force_b is active this cycle (debug/perf)

Behaviour:
- Handshake: transfer when valid && ready. valid must hold with reg/data stable until the transfer. ready is combinational from valid and internal state only.
- Starvation counter wait_cnt, 8 bits:
  - Increments when b_valid && !b_ready.
  - Clears when B transfers or b_valid is low.
  - Saturates at MAX_WAIT.
- force_b = (wait_cnt == MAX_WAIT).
- Grant rules:
  - force_b=0: a_ready=1; b_ready = !a_valid.
  - force_b=1: b_ready=1; a_ready = !b_valid (b_valid is necessarily 1, so A stalls).
  - Exactly one transfer per cycle at most.
  - b_starved = force_b.
- Output register, next edge after a transfer in cycle N:
  - Cycle N+1: RegWrite = (granted reg != 0); Write_Reg_Num = granted reg; reg_write_data = granted data.
  - Cycle after a cycle with no transfer: RegWrite=0. Write_Reg_Num and reg_write_data hold their previous values.
- Latency: fixed 1 cycle, transfer to RegWrite. Throughput: 1 write/cycle.
- Register 0: transfer is accepted (ready as normal) but RegWrite stays 0. This applies to both requesters.
- Same destination on A and B in the same cycle: granted side writes first; the other writes in a later cycle. Ordering between A and B results to the same register is the hazard unit's responsibility. The arbiter never reorders within one requester.
- Reset (reset==0, asynchronous, any time including mid-transfer):
  - RegWrite=0, Write_Reg_Num=0, reg_write_data=0, wait_cnt=0.
  - Any pending request is dropped; requesters re-present after reset.
  - a_ready/b_ready follow the combinational rules using wait_cnt=0.
- Counter boundaries:
  - MAX_WAIT=1: B is forced on the 2nd consecutive refused cycle.
  - wait_cnt never exceeds MAX_WAIT.

Optional Feature:
Macro: REGWR_ARB_STATS_EN
- Defined: adds output ports a_writes [15:0], b_writes [15:0], b_stall_cycles [15:0].
  - a_writes / b_writes count accepted transfers per requester; $0 transfers are included.
  - b_stall_cycles counts cycles with b_valid && !b_ready.
  - All counters saturate at 16'hFFFF and clear on reset.
- Not defined: these ports and counters do not exist. Core behaviour is identical.

Test Plan:
1. Reset then single writes: A writes reg 5 = 32'hDEADBEEF in cycle 3 -> cycle 4 RegWrite=1, Write_Reg_Num=5, data=DEADBEEF; cycle 5 RegWrite=0.
2. Simultaneous requests, MAX_WAIT=4: A valid every cycle, B valid from cycle 0 with reg 7 -> B refused cycles 0-3; cycle 4 b_ready=1, a_ready=0, b_starved=1; RegWrite for reg 7 in cycle 5; A resumes in cycle 5.
3. $0 suppression: A transfers reg 0 data 32'h1234 -> a_ready=1, following cycle RegWrite=0.
4. Back-to-back throughput: A alone writes regs 1..8 on 8 consecutive cycles -> 8 consecutive RegWrite pulses with matching addresses and data, no bubbles.
5. Reset mid-operation: B waiting with wait_cnt=3, assert reset asynchronously between edges -> RegWrite drops to 0 immediately; after release B needs 4 more refused cycles before force.
6. With REGWR_ARB_STATS_EN: run scenario 2 for 20 cycles -> a_writes, b_writes and b_stall_cycles equal the bench-counted values.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port between
// the writeback stage (A, fixed priority) and the multi-cycle unit (B).
// A starvation counter force-grants B after MAX_WAIT consecutive refusals.
// The granted write is registered; $0 writes are accepted but never enabled.
// Optional statistics counters are compiled in with `define REGWR_ARB_STATS_EN.
module regfile_write_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        RegWrite,
  output logic [4:0]  Write_Reg_Num,
  output logic [31:0] reg_write_data,
  output logic        b_starved
`ifdef REGWR_ARB_STATS_EN
  ,
  output logic [15:0] a_writes,
  output logic [15:0] b_writes,
  output logic [15:0] b_stall_cycles
`endif
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  wr_reg_q, wr_reg_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        force_b;
  logic        a_xfer, b_xfer;

  // Grant: A wins unless B has waited MAX_WAIT cycles; at most one transfer.
  always_comb begin
    force_b = (wait_cnt_q == MAX_WAIT_C);
    if (force_b) begin
      b_ready = 1'b1;
      a_ready = !b_valid;
    end else begin
      a_ready = 1'b1;
      b_ready = !a_valid;
    end
    a_xfer    = a_valid && a_ready;
    b_xfer    = b_valid && b_ready;
    b_starved = force_b;
  end

  // Next state: starvation count and the write-port contents for next cycle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!b_valid || b_xfer) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    regwrite_d = 1'b0;
    wr_reg_d   = wr_reg_q;
    wr_data_d  = wr_data_q;
    if (a_xfer) begin
      regwrite_d = (a_reg != 5'd0);
      wr_reg_d   = a_reg;
      wr_data_d  = a_data;
    end else if (b_xfer) begin
      regwrite_d = (b_reg != 5'd0);
      wr_reg_d   = b_reg;
      wr_data_d  = b_data;
    end
  end

  // State registers; reset drops any in-flight write immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= 8'd0;
      regwrite_q <= 1'b0;
      wr_reg_q   <= 5'd0;
      wr_data_q  <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      regwrite_q <= regwrite_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign RegWrite       = regwrite_q;
  assign Write_Reg_Num  = wr_reg_q;
  assign reg_write_data = wr_data_q;

`ifdef REGWR_ARB_STATS_EN
  logic [15:0] a_writes_q, b_writes_q, b_stall_q;

  // Saturating per-requester transfer and B stall counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_writes_q <= 16'd0;
      b_writes_q <= 16'd0;
      b_stall_q  <= 16'd0;
    end else begin
      if (a_xfer && a_writes_q != 16'hFFFF) a_writes_q <= a_writes_q + 16'd1;
      if (b_xfer && b_writes_q != 16'hFFFF) b_writes_q <= b_writes_q + 16'd1;
      if (b_valid && !b_ready && b_stall_q != 16'hFFFF) b_stall_q <= b_stall_q + 16'd1;
    end
  end

  assign a_writes       = a_writes_q;
  assign b_writes       = b_writes_q;
  assign b_stall_cycles = b_stall_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios plus random traffic.
// Expected register-file writes go into a scoreboard queue; a monitor process
// compares the write port every cycle. Build with REGWR_ARB_STATS_EN to also
// check the statistics counters.
module tb_regfile_write_arbiter;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_reg = 5'd0, b_reg = 5'd0;
  logic [31:0] a_data = 32'd0, b_data = 32'd0;
  logic        a_ready, b_ready, RegWrite, b_starved;
  logic [4:0]  Write_Reg_Num;
  logic [31:0] reg_write_data;
`ifdef REGWR_ARB_STATS_EN
  logic [15:0] a_writes, b_writes, b_stall_cycles;
`endif

  regfile_write_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .RegWrite(RegWrite), .Write_Reg_Num(Write_Reg_Num),
    .reg_write_data(reg_write_data), .b_starved(b_starved)
`ifdef REGWR_ARB_STATS_EN
    , .a_writes(a_writes), .b_writes(b_writes), .b_stall_cycles(b_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic        we;
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;

  // Reference state: how long B has been refused, last write-port contents,
  // and per-requester counts since reset.
  int          refused = 0;
  logic [4:0]  last_r = 5'd0;
  logic [31:0] last_d = 32'd0;
  int          n_a = 0, n_b = 0, n_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus; readies are predicted from the arbitration
  // rules and the predicted transfer is pushed to the scoreboard.
  task automatic do_cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                          input logic bv, input logic [4:0] br, input logic [31:0] bd,
                          output logic ax, output logic bx);
    logic forced, ea, eb;
    exp_t e;
    @(posedge clk);
    #1;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    @(negedge clk);
    forced = (refused >= MAX_WAIT);
    ea = !(forced && bv);
    eb = forced || !av;
    chk("a_ready", {31'd0, a_ready}, {31'd0, ea});
    chk("b_ready", {31'd0, b_ready}, {31'd0, eb});
    chk("b_starved", {31'd0, b_starved}, {31'd0, forced});
    ax = av && ea;
    bx = bv && eb;
    if (ax || bx) begin
      e.at = cyc + 1;
      e.r  = ax ? ar : br;
      e.d  = ax ? ad : bd;
      e.we = (e.r != 5'd0);
      q.push_back(e);
      $display("cycle %0d: %s transfer reg=%0d data=%h", cyc, ax ? "A" : "B", e.r, e.d);
    end
    if (ax) n_a++;
    if (bx) n_b++;
    if (bv && !bx) begin
      n_stall++;
      if (refused < MAX_WAIT) refused++;
    end else begin
      refused = 0;
    end
  endtask

  // Monitor: every cycle the write port must match the scoreboard head or idle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (!reset) begin
        chk("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_reg", {27'd0, Write_Reg_Num}, 32'd0);
        chk("rst_data", reg_write_data, 32'd0);
      end else begin
        while (q.size() > 0 && q[0].at < cyc) begin
          e = q.pop_front();
          chk("missed_write_cycle", 32'(cyc), 32'(e.at));
        end
        if (q.size() > 0 && q[0].at == cyc) begin
          e = q.pop_front();
          chk("RegWrite", {31'd0, RegWrite}, {31'd0, e.we});
          chk("Write_Reg_Num", {27'd0, Write_Reg_Num}, {27'd0, e.r});
          chk("reg_write_data", reg_write_data, e.d);
          last_r = e.r;
          last_d = e.d;
        end else begin
          chk("idle_RegWrite", {31'd0, RegWrite}, 32'd0);
          chk("hold_reg", {27'd0, Write_Reg_Num}, {27'd0, last_r});
          chk("hold_data", reg_write_data, last_d);
        end
      end
    end
  end

  task automatic model_reset();
    q.delete();
    refused = 0;
    last_r = 5'd0;
    last_d = 32'd0;
    n_a = 0; n_b = 0; n_stall = 0;
  endtask

`ifdef REGWR_ARB_STATS_EN
  task automatic chk_stats();
    @(negedge clk);
    chk("a_writes", {16'd0, a_writes}, 32'(n_a));
    chk("b_writes", {16'd0, b_writes}, 32'(n_b));
    chk("b_stall_cycles", {16'd0, b_stall_cycles}, 32'(n_stall));
  endtask
`endif

  initial begin
    logic ax, bx;
    logic a_pend, b_pend;
    logic [4:0] ar, br;
    logic [31:0] ad, bd;
    int k;

    // Readies during reset follow the rules with an empty wait count.
    a_valid = 1'b1; b_valid = 1'b1;
    #2;
    chk("rst_a_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_b_starved", {31'd0, b_starved}, 32'd0);
    a_valid = 1'b0;
    #1;
    chk("rst_b_ready_alone", {31'd0, b_ready}, 32'd1);
    b_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single write of reg 5, then idle.
    do_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ax, bx);
    do_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, ax, bx);
    repeat (2) do_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ax, bx);

    // A busy every cycle; B (reg 7) must win on its (MAX_WAIT+1)-th cycle.
    k = 0;
    bx = 1'b0;
    while (!bx && k < 20) begin
      do_cycle(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'd7, 32'h0000_0777, ax, bx);
      k++;
    end
    chk("force_after_max_wait", 32'(k), 32'(MAX_WAIT + 1));
    do_cycle(1'b1, 5'd3, 32'h3333_3333, 1'b0, 5'd0, 32'd0, ax, bx);

    // $0 write is accepted but never enabled.
    do_cycle(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, ax, bx);
    chk("reg0_accepted", {31'd0, ax}, 32'd1);
    do_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ax, bx);

    // Back-to-back throughput: regs 1..8.
    for (int i = 1; i <= 8; i++)
      do_cycle(1'b1, 5'(i), 32'hA000_0000 + 32'(i), 1'b0, 5'd0, 32'd0, ax, bx);
    do_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ax, bx);

    // B refused three times, then asynchronous reset between edges.
    for (int i = 0; i < 3; i++)
      do_cycle(1'b1, 5'd9, 32'h9999_0000 + 32'(i), 1'b1, 5'd11, 32'h0000_00BB, ax, bx);
    @(posedge clk);
    #4;
    reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    model_reset();
    #1;
    chk("async_RegWrite", {31'd0, RegWrite}, 32'd0);
    chk("async_reg", {27'd0, Write_Reg_Num}, 32'd0);
    chk("async_data", reg_write_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    bx = 1'b0;
    while (!bx && k < 20) begin
      do_cycle(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'd11, 32'h0000_00BB, ax, bx);
      k++;
    end
    chk("force_after_reset", 32'(k), 32'(MAX_WAIT + 1));
    do_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ax, bx);

`ifdef REGWR_ARB_STATS_EN
    // Statistics: fresh reset, then 20 cycles of contention.
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    b_pend = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!b_pend) begin b_pend = 1'b1; br = 5'($urandom); bd = $urandom; end
      do_cycle(1'b1, 5'($urandom), $urandom, 1'b1, br, bd, ax, bx);
      if (bx) b_pend = 1'b0;
    end
    chk_stats();
`endif

    // Random traffic obeying the hold-until-accepted rule.
    a_pend = 1'b0; b_pend = 1'b0;
    ar = 5'd0; br = 5'd0; ad = 32'd0; bd = 32'd0;
    for (int i = 0; i < 400; i++) begin
      if (!a_pend && $urandom_range(0, 99) < (i < 200 ? 55 : 95)) begin
        a_pend = 1'b1; ar = 5'($urandom); ad = $urandom;
      end
      if (!b_pend && $urandom_range(0, 99) < 40) begin
        b_pend = 1'b1; br = 5'($urandom); bd = $urandom;
      end
      do_cycle(a_pend, ar, ad, b_pend, br, bd, ax, bx);
      if (ax) a_pend = 1'b0;
      if (bx) b_pend = 1'b0;
    end
    repeat (3) do_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ax, bx);
`ifdef REGWR_ARB_STATS_EN
    chk_stats();
`endif
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
